servant_sleep_ctrl: RTL

Power-management sequencer between the servant SoC and the board clock generator.
- Accepts the core's sleep request, the timer wakeup request and a raw asynchronous external interrupt.
- Makes sure the Wishbone bus is idle before it gates the CPU clock.
- Drives the clock-enable input of the clock generator and passes a synchronised interrupt to the core.
- Counts the cycles spent asleep for software profiling.

---
 rtl/servant_sleep_ctrl_pkg.sv | 26 ++
 rtl/servant_sync.sv | 24 ++
 rtl/servant_sleep_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/servant_sleep_ctrl_pkg.sv
// rtl/servant_sleep_ctrl_pkg.sv - shared state encodings, defaults and sizing helper
package servant_sleep_ctrl_pkg;

  // Sequencer states; encodings are fixed so board top and bench agree
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_SLEEP = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_WAKE_DELAY   = 2;
  localparam int DEF_CNT_W        = 32;

  // Width of the shared drain/wake down-counter, never below one bit
  function automatic int dcnt_width(input int drain_cycles, input int wake_delay);
    int m;
    int w;
    m = (drain_cycles > wake_delay) ? drain_cycles : wake_delay;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/servant_sync.sv
// rtl/servant_sync.sv - N-stage reset-to-0 flop synchroniser for asynchronous board inputs
module servant_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; the last stage is the safe copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/servant_sleep_ctrl.sv
// rtl/servant_sleep_ctrl.sv - sleep/wake sequencer that gates the CPU clock once the bus is idle
module servant_sleep_ctrl
  import servant_sleep_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int WAKE_DELAY   = DEF_WAKE_DELAY,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sleep_req,
  input  logic             i_wakeup_req,
  input  logic             i_ext_irq,
  input  logic             i_wb_cyc,
  output logic             o_clk_en,
  output logic             o_irq,
  output logic             o_sleeping,
  output logic [CNT_W-1:0] o_sleep_cycles
);

  localparam int DW = dcnt_width(DRAIN_CYCLES, WAKE_DELAY);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] WAKE_LOAD  = DW'(WAKE_DELAY);
  localparam logic [DW-1:0] DCNT_ONE   = DW'(1);

  state_t           state;
  logic [DW-1:0]    dcnt;
  logic             wake;
  logic [CNT_W-1:0] sleep_cycles_inc;

  servant_sync #(
    .STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_ext_irq),
    .q    (o_irq)
  );

  // A held interrupt counts as a wake, so it also blocks entry to sleep
  assign wake = i_wakeup_req | o_irq;

  // Profiling counter sticks at all-ones instead of wrapping
  assign sleep_cycles_inc = (&o_sleep_cycles) ? o_sleep_cycles
                                              : o_sleep_cycles + CNT_W'(1);

  // Sequencer; clock enable is its own flop so the gate input never sees a state decode
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_RUN;
      dcnt           <= '0;
      o_clk_en       <= 1'b1;
      o_sleeping     <= 1'b0;
      o_sleep_cycles <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (i_sleep_req && !wake) begin
            state <= S_DRAIN;
            dcnt  <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (wake) begin
            state <= S_RUN;
          end else if (i_wb_cyc) begin
            dcnt <= DRAIN_LOAD;
          end else if (dcnt != '0) begin
            dcnt <= dcnt - DCNT_ONE;
          end else begin
            state          <= S_SLEEP;
            o_clk_en       <= 1'b0;
            o_sleeping     <= 1'b1;
            o_sleep_cycles <= '0;
          end
        end
        S_SLEEP: begin
          o_sleep_cycles <= sleep_cycles_inc;
          if (wake) begin
            state <= S_WAKE;
            dcnt  <= WAKE_LOAD;
          end
        end
        S_WAKE: begin
          // Leave when the decremented count reaches zero; a zero delay still spends one cycle here
          o_sleep_cycles <= sleep_cycles_inc;
          if (dcnt <= DCNT_ONE) begin
            state      <= S_RUN;
            dcnt       <= '0;
            o_clk_en   <= 1'b1;
            o_sleeping <= 1'b0;
          end else begin
            dcnt <= dcnt - DCNT_ONE;
          end
        end
        default: begin
          state      <= S_RUN;
          dcnt       <= '0;
          o_clk_en   <= 1'b1;
          o_sleeping <= 1'b0;
        end
      endcase
    end
  end

endmodule
